booth_pp_gen: RTL and testbench
===============================

// Module: booth_pp_gen
// PURPOSE
//   Radix-4 Booth partial-product generator directly upstream of the 64-column Wallace tree.
//   - Accepts one 32x32 signed/unsigned multiply request.
//   - Builds 17 fully sign-extended 64-bit partial-product rows.
//   - Transposes the rows into 64 column vectors of 17 bits each.
//   - Holds the columns stable with mwt_begin high until the tree reports wt_end.
// PARAMETERS
//   WIDTH  32                 operand width; only 32 is supported
//   NPP    WIDTH/2+1 (17)     partial-product rows = bits per column
//   NCOL   2*WIDTH (64)       product columns
// PORTS
//   clk         in   1         clock; all state updates on posedge
//   resetn      in   1         asynchronous active-low reset
//   mul_begin   in   1         request strobe; sampled only in IDLE
//   mul_signed  in   1         1 = two's-complement operands, 0 = unsigned
//   x           in   WIDTH     multiplicand
//   y           in   WIDTH     multiplier (Booth-recoded operand)
//   busy        out  1         high in PREP, GEN and WAIT
//   mwt_begin   out  1         tree start level; high in WAIT
//   tree_cols   out  NCOL*NPP  column k (Tree k+1) = tree_cols[NPP*k +: NPP]
//   wt_end      in   1         tree done pulse; honoured only in WAIT
// BEHAVIOUR
// - Reset (resetn=0, asynchronous) forces:
//   - state to IDLE;
//   - busy=0, mwt_begin=0, tree_cols=0;
//   - all operand and multiple registers to 0.
//   Reset in any state aborts the operation; no partial result survives.
// - FSM states: IDLE -> PREP -> GEN -> WAIT -> IDLE.
//   - IDLE: if mul_begin=1, latch x, y and mul_signed, then go to PREP. Otherwise stay.
//   - PREP: form 64-bit multiples of X, then go to GEN.
//     - X is x zero-extended (unsigned) or sign-extended (signed) to 64 bits.
//     - Register +X, +2X, -X and -2X (all mod 2^64).
//     - This cycle contains the only adder (the negation).
//   - GEN: Booth-select, shift and transpose all rows into the tree_cols register, then go to WAIT.
//   - WAIT: mwt_begin=1 and tree_cols is held constant.
//     - When wt_end=1 is sampled, go to IDLE; mwt_begin is 0 from the next cycle.
//     - tree_cols keeps its value after leaving WAIT until the next GEN overwrites it.
// - mul_begin outside IDLE is ignored (not queued).
//   - mul_begin in the same cycle WAIT exits is also ignored.
//   - An accepted mul_begin sets busy=1 on the next cycle.
// - wt_end outside WAIT is ignored.
// - Latency: if mul_begin is sampled at edge 0, mwt_begin=1 and tree_cols are valid after edge 2.
//   - The minimum request-to-request interval is 3 cycles plus the tree time.
// - Booth recoding:
//   - Extended multiplier Y' (35 bits):
//     - unsigned: {2'b00, y, 1'b0}
//     - signed:   {{2{y[31]}}, y, 1'b0}
//   - Row i (i = 0..16) uses digit d = Y'[2i+2:2i]:
//     - 000, 111 -> 0
//     - 001, 010 -> +X
//     - 011      -> +2X
//     - 100      -> -2X
//     - 101, 110 -> -X
//   - row_i = (multiple << 2i) truncated to 64 bits. No separate +1 or sign-compensation bits are used.
//   - For signed operands row 16 is always 0.
// - Transpose: tree_cols[NPP*k + i] = row_i[k], for k = 0..63 and i = 0..16.
// - Invariant: the sum over all rows (mod 2^64) equals the full 64-bit product.
//   The column sum sum_k popcount(col_k)*2^k (mod 2^64) gives the same value.
// TESTING
// - Unsigned 3 x 5: after 2 cycles mwt_begin=1 and the columns sum to 64'd15.
//   Column 0 = 17'b1 (row0 = +X = 3).
// - Signed -1 x -1 (32'hFFFFFFFF both): the column sum is 64'd1. Row 16 is all zero.
// - Unsigned 32'hFFFFFFFF x 32'hFFFFFFFF: the column sum is 64'hFFFFFFFE_00000001.
//   Row 16 is nonzero.
// - Signed 32'h80000000 x 32'h80000000: the column sum is 64'h40000000_00000000.
//   Signed 32'h80000000 x 1: the column sum is 64'hFFFFFFFF_80000000.
// - Handshake with mwt_begin held high:
//   - mul_begin pulsed with new operands while in WAIT: no state change, tree_cols unchanged.
//   - wt_end=1 for 1 cycle: mwt_begin and busy go to 0 on the next edge.
//   - A new mul_begin is then accepted.
// - Reset mid-operation: assert resetn=0 while in GEN and while in WAIT.
//   - busy, mwt_begin and tree_cols are 0 immediately, without waiting for a clock edge.
//   - After release, the next request completes normally.
//   - Also run randomised signed and unsigned operands against a reference model of the column sum.

Source files
------------

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator feeding a 64-column Wallace tree.
// Latency: request accepted at edge 0 -> columns valid and mwt_begin high after edge 2.
// Backpressure: holds columns with mwt_begin high until wt_end; new requests are dropped while busy.
//
// Ports:
//   clk, resetn           clock and asynchronous active-low reset
//   mul_begin             request strobe, only looked at in IDLE
//   mul_signed            1 = two's-complement operands, 0 = unsigned
//   x, y                  multiplicand, multiplier (y is Booth-recoded)
//   busy                  high while an operation is in PREP, GEN or WAIT
//   mwt_begin             tree start level, high in WAIT
//   tree_cols             column k = tree_cols[NPP*k +: NPP], bit i = row i
//   wt_end                tree done pulse, only looked at in WAIT
module booth_pp_gen #(
  parameter int WIDTH = 32,
  parameter int NPP   = WIDTH / 2 + 1,
  parameter int NCOL  = 2 * WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mul_begin,
  input  logic                  mul_signed,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      y,
  output logic                  busy,
  output logic                  mwt_begin,
  output logic [NCOL*NPP-1:0]   tree_cols,
  input  logic                  wt_end
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_GEN  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operands
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             sgn_q;

  // Registered Booth multiples of the 64-bit extended multiplicand
  logic [NCOL-1:0]  m_px;
  logic [NCOL-1:0]  m_p2x;
  logic [NCOL-1:0]  m_nx;
  logic [NCOL-1:0]  m_n2x;

  // Combinational helpers
  logic [NCOL-1:0]    x_ext;
  logic [NCOL-1:0]    x_neg;
  logic [WIDTH+2:0]   y_ext;
  logic [2:0]         digit;
  logic [NCOL-1:0]    mult;
  logic [NCOL-1:0]    rows [NPP];
  logic [NCOL*NPP-1:0] cols_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mwt_begin = 1'b0;
    case (state)
      S_IDLE: begin
        if (mul_begin) state_nxt = S_PREP;
      end
      S_PREP: begin
        busy      = 1'b1;
        state_nxt = S_GEN;
      end
      S_GEN: begin
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        mwt_begin = 1'b1;
        if (wt_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplicand extension and the single negation adder
  // ---------------------------------------------------------------------------
  always_comb begin
    x_ext = {{WIDTH{sgn_q & x_q[WIDTH-1]}}, x_q};
    x_neg = ~x_ext + {{(NCOL-1){1'b0}}, 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Booth select, shift and transpose
  // ---------------------------------------------------------------------------
  always_comb begin
    // Two extra top bits make the last digit (row NPP-1) see a proper sign
    // or zero extension; for signed operands it is always 000/111 -> 0.
    y_ext    = sgn_q ? {{2{y_q[WIDTH-1]}}, y_q, 1'b0} : {2'b00, y_q, 1'b0};
    digit    = 3'b000;
    mult     = '0;
    cols_nxt = '0;
    for (int i = 0; i < NPP; i++) begin
      digit = y_ext[2*i +: 3];
      case (digit)
        3'b001, 3'b010: mult = m_px;
        3'b011:         mult = m_p2x;
        3'b100:         mult = m_n2x;
        3'b101, 3'b110: mult = m_nx;
        default:        mult = '0;
      endcase
      // Multiples are already full 64-bit two's-complement values, so the
      // truncated shift is a complete, sign-extended row.
      rows[i] = mult << (2 * i);
    end
    for (int k = 0; k < NCOL; k++) begin
      for (int i = 0; i < NPP; i++) begin
        cols_nxt[NPP*k + i] = rows[i][k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
    end else if (state == S_IDLE && mul_begin) begin
      x_q   <= x;
      y_q   <= y;
      sgn_q <= mul_signed;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_px  <= '0;
      m_p2x <= '0;
      m_nx  <= '0;
      m_n2x <= '0;
    end else if (state == S_PREP) begin
      m_px  <= x_ext;
      m_p2x <= x_ext << 1;
      m_nx  <= x_neg;
      m_n2x <= x_neg << 1;
    end
  end

  // Columns persist after WAIT until the next GEN replaces them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tree_cols <= '0;
    end else if (state == S_GEN) begin
      tree_cols <= cols_nxt;
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen: directed and random multiplies,
// WAIT handshake, ignored strobes and asynchronous reset mid-operation.
module tb_booth_pp_gen;

  localparam int NPP  = 17;
  localparam int NCOL = 64;

  logic                clk;
  logic                resetn;
  logic                mul_begin;
  logic                mul_signed;
  logic [31:0]         x;
  logic [31:0]         y;
  logic                busy;
  logic                mwt_begin;
  logic [NCOL*NPP-1:0] tree_cols;
  logic                wt_end;

  booth_pp_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .mul_begin  (mul_begin),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .mwt_begin  (mwt_begin),
    .tree_cols  (tree_cols),
    .wt_end     (wt_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // r16: 0 = no row-16 check, 1 = must be zero, 2 = must be nonzero
  typedef struct {
    logic [63:0] sum;
    int          r16;
    logic        chk_c0;
    logic [16:0] c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen   = 0;
  exp_t e_mon;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] col_sum(input logic [NCOL*NPP-1:0] c);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < NCOL; k++)
      for (int i = 0; i < NPP; i++)
        if (c[NPP*k + i]) s = s + (64'd1 << k);
    return s;
  endfunction

  function automatic logic [63:0] row16(input logic [NCOL*NPP-1:0] c);
    logic [63:0] r;
    for (int k = 0; k < NCOL; k++) r[k] = c[NPP*k + 16];
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] sum, input int r16,
                              input logic chk_c0, input logic [16:0] c0);
    exp_t e;
    e.sum = sum; e.r16 = r16; e.chk_c0 = chk_c0; e.c0 = c0;
    return e;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic signed [63:0] sa, sbv;
    if (s) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      return sa * sbv;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Monitor: compares the column set once each time mwt_begin rises.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1 || mwt_begin !== 1'b1) begin
        seen = 0;
      end else if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: mwt_begin rose with no pending request");
        end else begin
          e_mon = sb.pop_front();
          chk("col_sum", col_sum(tree_cols), e_mon.sum);
          if (e_mon.r16 == 1) chk("row16_zero", row16(tree_cols), 64'd0);
          else if (e_mon.r16 == 2) chk("row16_nonzero", {63'd0, |row16(tree_cols)}, 64'd1);
          if (e_mon.chk_c0) chk("col0", {47'd0, tree_cols[16:0]}, {47'd0, e_mon.c0});
        end
      end
    end
  end

  // Issue a request and follow it to WAIT; ign holds wt_end high through
  // IDLE/PREP/GEN where it must have no effect.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic ign);
    @(negedge clk);
    x = a; y = b; mul_signed = s; mul_begin = 1'b1; wt_end = ign;
    @(negedge clk);
    mul_begin = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("mwt_in_prep", {63'd0, mwt_begin}, 64'd0);
    @(negedge clk);
    chk("mwt_in_gen", {63'd0, mwt_begin}, 64'd0);
    @(negedge clk);
    wt_end = 1'b0;
    chk("mwt_after_2", {63'd0, mwt_begin}, 64'd1);
    chk("busy_in_wait", {63'd0, busy}, 64'd1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input exp_t e, input logic ign);
    sb.push_back(e);
    start(a, b, s, ign);
  endtask

  // Hold WAIT for a while, then pulse wt_end (optionally with a mul_begin
  // in the same cycle, which must be dropped).
  task automatic finish(input int hold, input logic try_begin);
    repeat (hold) @(negedge clk);
    chk("mwt_held", {63'd0, mwt_begin}, 64'd1);
    wt_end = 1'b1; mul_begin = try_begin; x = 32'h1234_5678; y = 32'h9ABC_DEF0;
    @(negedge clk);
    wt_end = 1'b0; mul_begin = 1'b0;
    chk("mwt_after_end", {63'd0, mwt_begin}, 64'd0);
    chk("busy_after_end", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("idle_stays", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    resetn = 1'b0; mul_begin = 1'b0; mul_signed = 1'b0; x = '0; y = '0; wt_end = 1'b0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_mwt", {63'd0, mwt_begin}, 64'd0);
    chk("reset_cols", {63'd0, |tree_cols}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Unsigned 3 x 5, wt_end ignored before WAIT, then mul_begin ignored in WAIT.
    op(32'd3, 32'd5, 1'b0, mk(64'd15, 0, 1'b1, 17'b1), 1'b1);
    @(negedge clk);
    x = 32'd7; y = 32'd9; mul_signed = 1'b1; mul_begin = 1'b1;
    @(negedge clk);
    mul_begin = 1'b0;
    chk("wait_cols_held", col_sum(tree_cols), 64'd15);
    chk("wait_mwt_held", {63'd0, mwt_begin}, 64'd1);
    chk("wait_busy_held", {63'd0, busy}, 64'd1);
    finish(1, 1'b1);

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(64'd1, 1, 1'b0, 17'd0), 1'b0);
    finish(2, 1'b0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(64'hFFFF_FFFE_0000_0001, 2, 1'b0, 17'd0), 1'b0);
    finish(0, 1'b0);
    op(32'h8000_0000, 32'h8000_0000, 1'b1, mk(64'h4000_0000_0000_0000, 1, 1'b0, 17'd0), 1'b0);
    finish(1, 1'b0);
    op(32'h8000_0000, 32'd1, 1'b1, mk(64'hFFFF_FFFF_8000_0000, 1, 1'b0, 17'd0), 1'b0);
    finish(1, 1'b0);

    // Reset while in GEN: previous columns are nonzero, must clear at once.
    @(negedge clk);
    x = 32'd11; y = 32'd13; mul_signed = 1'b0; mul_begin = 1'b1;
    @(negedge clk);
    mul_begin = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_gen_busy", {63'd0, busy}, 64'd0);
    chk("rst_gen_mwt", {63'd0, mwt_begin}, 64'd0);
    chk("rst_gen_cols", {63'd0, |tree_cols}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    op(32'd100, 32'hFFFF_FFFD, 1'b1, mk(64'hFFFF_FFFF_FFFF_FED4, 1, 1'b0, 17'd0), 1'b0);
    finish(1, 1'b0);

    // Reset while in WAIT.
    op(32'd6, 32'd7, 1'b0, mk(64'd42, 0, 1'b0, 17'd0), 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_wait_busy", {63'd0, busy}, 64'd0);
    chk("rst_wait_mwt", {63'd0, mwt_begin}, 64'd0);
    chk("rst_wait_cols", {63'd0, |tree_cols}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    op(32'd12345, 32'd678, 1'b0, mk(64'd8369910, 0, 1'b0, 17'd0), 1'b0);
    finish(1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      op(a, b, s, mk(ref_prod(a, b, s), s ? 1 : 0, 1'b0, 17'd0), 1'b0);
      finish($urandom_range(0, 3), 1'b0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
